// File: rtl/video_timing_pkg.sv
// Shared types for the video timing generator: axis region encoding and line/frame length helper.
// Pure declarations, no latency; no flow control.
package video_timing_pkg;

    typedef enum logic [1:0] {
        FP     = 2'd0,
        SYNC   = 2'd1,
        BP     = 2'd2,
        ACTIVE = 2'd3
    } region_e;

    function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/timing_axis.sv
// Signed wrap counter for one timing axis: counts -BLANK .. ACTIVE-1 and decodes the region of the next position.
// Position is registered; the next-state region and wrap flag are combinational from the current state.
// Holds whenever adv_i is low.
module timing_axis
    import video_timing_pkg::*;
#(
    parameter int W        = 16,
    parameter int N_ACTIVE = 320,
    parameter int N_FP     = 8,
    parameter int N_SYNC   = 32,
    parameter int N_BP     = 40
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                adv_i,
    output logic signed [W-1:0] pos_o,
    output region_e             region_d_o,
    output logic                wrap_o
);

    localparam int BLANK = axis_total(N_ACTIVE, N_FP, N_SYNC, N_BP) - N_ACTIVE;

    localparam longint HI = (longint'(1) <<< (W - 1)) - 1;
    localparam longint LO = -(longint'(1) <<< (W - 1));

    if (longint'(N_ACTIVE - 1) > HI || -longint'(BLANK) < LO) begin : g_bad_width
        $error("timing_axis: coordinate range does not fit in W bits");
    end

    if (N_FP < 1 || N_SYNC < 1 || N_BP < 1) begin : g_bad_porch
        $error("timing_axis: porch and sync widths must be at least 1");
    end

    localparam logic signed [W-1:0] FIRST    = W'(-BLANK);
    localparam logic signed [W-1:0] LAST     = W'(N_ACTIVE - 1);
    localparam logic signed [W-1:0] SYNC_AT  = W'(-(N_SYNC + N_BP));
    localparam logic signed [W-1:0] BP_AT    = W'(-N_BP);
    localparam logic signed [W-1:0] ONE      = W'(1);

    logic signed [W-1:0] pos_q;
    logic signed [W-1:0] pos_d;
    logic                at_last;

    // Region boundaries are fixed, so decode is three signed compares.
    function automatic region_e decode(input logic signed [W-1:0] p);
        if (p < SYNC_AT) begin
            return FP;
        end else if (p < BP_AT) begin
            return SYNC;
        end else if (p[W-1]) begin
            return BP;
        end else begin
            return ACTIVE;
        end
    endfunction

    always_comb begin
        at_last    = (pos_q == LAST);
        wrap_o     = adv_i && at_last;
        pos_d      = pos_q;
        if (adv_i) begin
            pos_d = at_last ? FIRST : pos_q + ONE;
        end
        region_d_o = decode(pos_d);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pos_q <= FIRST;
        end else begin
            pos_q <= pos_d;
        end
    end

    assign pos_o = pos_q;

endmodule

// File: rtl/video_timing.sv
// Raster timing generator: x/y position, hsync/vsync/de and line/frame start pulses, all registered.
// Outputs show the post-advance position in the cycle of the advance (no extra pipeline stage).
// Define VIDEO_TIMING_CE_EN to add a ce input; with ce low everything holds and the pulses read 0.
module video_timing
    import video_timing_pkg::*;
#(
    parameter int COORD_WIDTH = 16,
    parameter int H_ACTIVE    = 320,
    parameter int H_FP        = 8,
    parameter int H_SYNC      = 32,
    parameter int H_BP        = 40,
    parameter int V_ACTIVE    = 240,
    parameter int V_FP        = 3,
    parameter int V_SYNC      = 4,
    parameter int V_BP        = 6,
    parameter bit H_SYNC_POL  = 1'b1,
    parameter bit V_SYNC_POL  = 1'b1
) (
    input  logic                          clk,
    input  logic                          reset_n,
`ifdef VIDEO_TIMING_CE_EN
    input  logic                          ce,
`endif
    output logic                          hsync,
    output logic                          vsync,
    output logic                          de,
    output logic signed [COORD_WIDTH-1:0] x,
    output logic signed [COORD_WIDTH-1:0] y,
    output logic                          line_start,
    output logic                          frame_start
);

    logic    adv;
    logic    adv_y;
    logic    x_wrap;
    logic    y_wrap;
    region_e x_rgn_d;
    region_e y_rgn_d;

`ifdef VIDEO_TIMING_CE_EN
    assign adv = ce;
`else
    assign adv = 1'b1;
`endif

    assign adv_y = adv && x_wrap;

    timing_axis #(
        .W        (COORD_WIDTH),
        .N_ACTIVE (H_ACTIVE),
        .N_FP     (H_FP),
        .N_SYNC   (H_SYNC),
        .N_BP     (H_BP)
    ) u_x_axis (
        .clk        (clk),
        .reset_n    (reset_n),
        .adv_i      (adv),
        .pos_o      (x),
        .region_d_o (x_rgn_d),
        .wrap_o     (x_wrap)
    );

    timing_axis #(
        .W        (COORD_WIDTH),
        .N_ACTIVE (V_ACTIVE),
        .N_FP     (V_FP),
        .N_SYNC   (V_SYNC),
        .N_BP     (V_BP)
    ) u_y_axis (
        .clk        (clk),
        .reset_n    (reset_n),
        .adv_i      (adv_y),
        .pos_o      (y),
        .region_d_o (y_rgn_d),
        .wrap_o     (y_wrap)
    );

    logic hsync_q, hsync_d;
    logic vsync_q, vsync_d;
    logic de_q, de_d;
    logic line_start_q, line_start_d;
    logic frame_start_q, frame_start_d;

    // Decoding from next-state regions keeps flags aligned with the registered x/y.
    always_comb begin
        hsync_d       = (x_rgn_d == SYNC) ? H_SYNC_POL : !H_SYNC_POL;
        vsync_d       = (y_rgn_d == SYNC) ? V_SYNC_POL : !V_SYNC_POL;
        de_d          = (x_rgn_d == ACTIVE) && (y_rgn_d == ACTIVE);
        line_start_d  = x_wrap;
        frame_start_d = x_wrap && y_wrap;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hsync_q       <= !H_SYNC_POL;
            vsync_q       <= !V_SYNC_POL;
            de_q          <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            de_q          <= de_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign de          = de_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_video_timing.sv
// Bench for video_timing on a 14x7 raster (8 active + 2/2/2 porch/sync per line, 4 + 1/1/1 lines).
// A second instance with H_SYNC_POL=0 runs in lockstep to cover inverted hsync.
module tb_video_timing;

    typedef struct {
        int x;
        int y;
        bit hs;
        bit vs;
        bit de;
        bit ls;
        bit fs;
    } exp_t;

    typedef struct {
        bit   ce;
        exp_t e;
    } vec_t;

    logic clk;
    logic reset_n;
    logic ce;

    logic               hs_a, vs_a, de_a, ls_a, fs_a;
    logic signed [15:0] x_a, y_a;
    logic               hs_b, vs_b, de_b, ls_b, fs_b;
    logic signed [15:0] x_b, y_b;

    int n_assert = 0;
    int n_fail   = 0;
    int mx, my;
    exp_t sb_q[$];
    vec_t vecs[14];

    video_timing #(
        .COORD_WIDTH(16), .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1)
    ) dut_a (
        .clk(clk), .reset_n(reset_n),
`ifdef VIDEO_TIMING_CE_EN
        .ce(ce),
`endif
        .hsync(hs_a), .vsync(vs_a), .de(de_a), .x(x_a), .y(y_a),
        .line_start(ls_a), .frame_start(fs_a)
    );

    video_timing #(
        .COORD_WIDTH(16), .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b1)
    ) dut_b (
        .clk(clk), .reset_n(reset_n),
`ifdef VIDEO_TIMING_CE_EN
        .ce(ce),
`endif
        .hsync(hs_b), .vsync(vs_b), .de(de_b), .x(x_b), .y(y_b),
        .line_start(ls_b), .frame_start(fs_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(input string name, input int act, input int exp);
        n_assert++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endfunction

    function automatic vec_t mk(input bit c, input int ex, input int ey, input bit hs, input bit vs,
                                input bit d, input bit ls, input bit fs);
        vec_t v;
        v.ce = c;
        v.e  = '{ex, ey, hs, vs, d, ls, fs};
        return v;
    endfunction

    // Reference raster: x in -6..7, y in -3..3; hsync at x=-4,-3; vsync at y=-2.
    task automatic model_step(input bit ce_v, output exp_t e);
        bit adv;
        bit ls;
        bit fs;
`ifdef VIDEO_TIMING_CE_EN
        adv = ce_v;
`else
        adv = 1'b1;
`endif
        ls = 1'b0;
        fs = 1'b0;
        if (adv) begin
            if (mx == 7) begin
                mx = -6;
                ls = 1'b1;
                if (my == 3) begin
                    my = -3;
                    fs = 1'b1;
                end else begin
                    my = my + 1;
                end
            end else begin
                mx = mx + 1;
            end
        end
        e.x  = mx;
        e.y  = my;
        e.hs = (mx == -4 || mx == -3);
        e.vs = (my == -2);
        e.de = (mx >= 0 && my >= 0);
        e.ls = ls;
        e.fs = fs;
    endtask

    task automatic sb_check();
        exp_t e;
        if (sb_q.size() == 0) begin
            chk("scoreboard_empty", 0, 1);
        end else begin
            e = sb_q.pop_front();
            chk("x", int'(x_a), e.x);
            chk("y", int'(y_a), e.y);
            chk("hsync", int'(hs_a), int'(e.hs));
            chk("vsync", int'(vs_a), int'(e.vs));
            chk("de", int'(de_a), int'(e.de));
            chk("line_start", int'(ls_a), int'(e.ls));
            chk("frame_start", int'(fs_a), int'(e.fs));
            chk("hsync_pol0", int'(hs_b), int'(!e.hs));
        end
    endtask

    task automatic tick(input bit ce_v);
        exp_t e;
        @(negedge clk);
        ce = ce_v;
        model_step(ce_v, e);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        sb_check();
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_x"}, int'(x_a), -6);
        chk({tag, "_y"}, int'(y_a), -3);
        chk({tag, "_de"}, int'(de_a), 0);
        chk({tag, "_hsync"}, int'(hs_a), 0);
        chk({tag, "_vsync"}, int'(vs_a), 0);
        chk({tag, "_line_start"}, int'(ls_a), 0);
        chk({tag, "_frame_start"}, int'(fs_a), 0);
        chk({tag, "_hsync_pol0"}, int'(hs_b), 1);
    endtask

    initial begin
        int ls_cnt;
        int fs_cnt;
        int guard;
        bit prev_ls;
        bit prev_fs;

        vecs[0]  = mk(1, -5, -3, 0, 0, 0, 0, 0);
        vecs[1]  = mk(1, -4, -3, 1, 0, 0, 0, 0);
        vecs[2]  = mk(1, -3, -3, 1, 0, 0, 0, 0);
        vecs[3]  = mk(1, -2, -3, 0, 0, 0, 0, 0);
        vecs[4]  = mk(1, -1, -3, 0, 0, 0, 0, 0);
        vecs[5]  = mk(1,  0, -3, 0, 0, 0, 0, 0);
        vecs[6]  = mk(1,  1, -3, 0, 0, 0, 0, 0);
        vecs[7]  = mk(1,  2, -3, 0, 0, 0, 0, 0);
        vecs[8]  = mk(1,  3, -3, 0, 0, 0, 0, 0);
        vecs[9]  = mk(1,  4, -3, 0, 0, 0, 0, 0);
        vecs[10] = mk(1,  5, -3, 0, 0, 0, 0, 0);
        vecs[11] = mk(1,  6, -3, 0, 0, 0, 0, 0);
        vecs[12] = mk(1,  7, -3, 0, 0, 0, 0, 0);
        vecs[13] = mk(1, -6, -2, 0, 1, 0, 1, 0);

        reset_n = 1'b0;
        ce      = 1'b1;
        mx      = -6;
        my      = -3;
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("reset");
        #1;
        reset_n = 1'b1;

        // First line after release, against the hand-written table.
        for (int i = 0; i < 14; i++) begin
            tick(vecs[i].ce);
            chk("tbl_x", int'(x_a), vecs[i].e.x);
            chk("tbl_y", int'(y_a), vecs[i].e.y);
            chk("tbl_hsync", int'(hs_a), int'(vecs[i].e.hs));
            chk("tbl_vsync", int'(vs_a), int'(vecs[i].e.vs));
            chk("tbl_de", int'(de_a), int'(vecs[i].e.de));
            chk("tbl_line_start", int'(ls_a), int'(vecs[i].e.ls));
            chk("tbl_frame_start", int'(fs_a), int'(vecs[i].e.fs));
        end

        // One full frame: 98 cycles, 7 line starts, 1 frame start at (-6,-3).
        ls_cnt = 0;
        fs_cnt = 0;
        for (int i = 0; i < 98; i++) begin
            tick(1'b1);
            if (ls_a) ls_cnt++;
            if (fs_a) begin
                fs_cnt++;
                chk("fs_at_x", int'(x_a), -6);
                chk("fs_at_y", int'(y_a), -3);
                chk("fs_with_ls", int'(ls_a), 1);
            end
        end
        chk("line_start_count", ls_cnt, 7);
        chk("frame_start_count", fs_cnt, 1);

        // Walk to (3,1), then reset between edges.
        guard = 0;
        while (!(mx == 3 && my == 1) && guard < 200) begin
            tick(1'b1);
            guard++;
        end
        chk("mid_x", int'(x_a), 3);
        chk("mid_y", int'(y_a), 1);
        chk("mid_de", int'(de_a), 1);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_state("async_reset");
        mx = -6;
        my = -3;
        repeat (2) @(posedge clk);
        #2;
        reset_n = 1'b1;

`ifdef VIDEO_TIMING_CE_EN
        prev_ls = 1'b0;
        prev_fs = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick((i % 2) == 0);
            chk("ls_single_cycle", int'(ls_a && prev_ls), 0);
            chk("fs_single_cycle", int'(fs_a && prev_fs), 0);
            prev_ls = ls_a;
            prev_fs = fs_a;
        end
`else
        prev_ls = 1'b0;
        prev_fs = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick(1'b1);
            chk("ls_single_cycle", int'(ls_a && prev_ls), 0);
            chk("fs_single_cycle", int'(fs_a && prev_fs), 0);
            prev_ls = ls_a;
            prev_fs = fs_a;
        end
`endif

        chk("scoreboard_drained", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
